// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue scheduler with latency scoreboard and divider tracking.
// Picks 0/1/2 of the two oldest buffered instructions each cycle, strictly in order.
module issue_scheduler #(
  parameter int LAT_LOAD = 2,
  parameter int LAT_MUL  = 3,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_stall,
  input  logic [1:0] i_is_valid,
  input  logic [4:0] i_a_rs1,
  input  logic [4:0] i_a_rs2,
  input  logic [4:0] i_a_rd,
  input  logic       i_a_we,
  input  logic [1:0] i_a_type,
  input  logic [4:0] i_b_rs1,
  input  logic [4:0] i_b_rs2,
  input  logic [4:0] i_b_rd,
  input  logic       i_b_we,
  input  logic [1:0] i_b_type,
  input  logic       i_div_done,
  output logic [1:0] o_usingNUM,
  output logic [1:0] o_issue_valid,
  output logic       o_div_start,
  output logic       o_div_busy
);
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;
  localparam logic [1:0] T_ALU = 2'd0, T_MEM = 2'd1, T_MUL = 2'd2, T_DIV = 2'd3;

  div_state_e       state_q, state_d;
  logic [4:0]       div_rd_q, div_rd_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [1:0]       issue_valid_q;
  logic             div_start_q;
  logic [31:0]      busy;
  logic             div_blk, a_ok, b_ok, raw_ab, issue_a, issue_b, a_div, b_div, div_issue;

  function automatic logic [CNT_W-1:0] lat(input logic [1:0] t);
    return t == T_MEM ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_MUL);
  endfunction

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++)
      busy[r] = cnt_q[r] != '0 || (state_q == DIV_BUSY && div_rd_q == 5'(r));
  end

  // a DIV may enter in the very cycle the previous one writes back
  assign div_blk = state_q == DIV_BUSY && !i_div_done;
  assign a_ok = !busy[i_a_rs1] && !busy[i_a_rs2] && !(i_a_we && busy[i_a_rd])
                && !(i_a_type == T_DIV && div_blk);
  assign b_ok = !busy[i_b_rs1] && !busy[i_b_rs2] && !(i_b_we && busy[i_b_rd])
                && !(i_b_type == T_DIV && div_blk);
  assign raw_ab = i_a_we && i_a_rd != '0 && (i_a_rd == i_b_rs1 || i_a_rd == i_b_rs2)
                  && i_a_type != T_ALU;
  assign issue_a = i_is_valid[1] && !i_stall && !i_flush && a_ok;
  assign issue_b = issue_a && i_is_valid[0] && b_ok && !raw_ab
                   && !(i_a_type == T_MEM && i_b_type == T_MEM)
                   && !(i_a_type[1] && i_b_type[1]);
  assign o_usingNUM = {issue_a && issue_b, issue_a ^ issue_b};
  assign a_div = issue_a && i_a_type == T_DIV;
  assign b_div = issue_b && i_b_type == T_DIV;
  assign div_issue = a_div || b_div;

  always_comb begin
    for (int r = 0; r < 32; r++)
      cnt_d[r] = i_flush ? '0 : cnt_q[r] != '0 ? cnt_q[r] - 1'b1 : '0;
    if (issue_a && i_a_we && i_a_rd != '0 && (i_a_type == T_MEM || i_a_type == T_MUL))
      cnt_d[i_a_rd] = lat(i_a_type);
    // slot B applied last so its latency wins on a shared rd
    if (issue_b && i_b_we && i_b_rd != '0 && (i_b_type == T_MEM || i_b_type == T_MUL))
      cnt_d[i_b_rd] = lat(i_b_type);
  end

  always_comb begin
    state_d  = i_flush ? DIV_IDLE : div_issue ? DIV_BUSY : i_div_done ? DIV_IDLE : state_q;
    div_rd_d = !div_issue ? div_rd_q
             : a_div ? (i_a_we ? i_a_rd : 5'd0) : (i_b_we ? i_b_rd : 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DIV_IDLE;
      div_rd_q      <= '0;
      issue_valid_q <= '0;
      div_start_q   <= 1'b0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      state_q       <= state_d;
      div_rd_q      <= div_rd_d;
      issue_valid_q <= {issue_a, issue_b};
      div_start_q   <= div_issue;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign o_issue_valid = issue_valid_q;
  assign o_div_start   = div_start_q;
  assign o_div_busy    = state_q == DIV_BUSY;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed vector table plus hand sequences for reset and mid-divide reset.
module tb_issue_scheduler;
  localparam int ALU = 0, MEM = 1, MUL = 2, DIV = 3;
  localparam logic [2:0] NC = 3'b000, F = 3'b100, S = 3'b010, D = 3'b001;

  typedef logic [17:0] ins_t;
  typedef struct {
    logic [2:0] ctl;
    logic [1:0] valid;
    ins_t       a;
    ins_t       b;
    logic [1:0] num;
    logic [1:0] iv;
    logic       st;
    logic       bz;
  } vec_t;

  logic       clk = 0, rst = 1, flush = 0, stall = 0, done = 0;
  logic [1:0] valid = 0;
  ins_t       a = '0, b = '0;
  logic [1:0] using_num, issue_valid;
  logic       div_start, div_busy;
  int         checks = 0, errors = 0;
  vec_t       tbl [32];

  issue_scheduler dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_is_valid(valid),
    .i_a_rs1(a[17:13]), .i_a_rs2(a[12:8]), .i_a_rd(a[7:3]), .i_a_we(a[2]), .i_a_type(a[1:0]),
    .i_b_rs1(b[17:13]), .i_b_rs2(b[12:8]), .i_b_rd(b[7:3]), .i_b_we(b[2]), .i_b_type(b[1:0]),
    .i_div_done(done), .o_usingNUM(using_num), .o_issue_valid(issue_valid),
    .o_div_start(div_start), .o_div_busy(div_busy)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(int t, int rd, int rs1, int rs2, logic we);
    return {5'(rs1), 5'(rs2), 5'(rd), we, 2'(t)};
  endfunction

  function automatic vec_t row(logic [2:0] c, logic [1:0] v, ins_t ia, ins_t ib,
                               logic [1:0] n, logic [1:0] iv, logic st, logic bz);
    vec_t r;
    r.ctl = c; r.valid = v; r.a = ia; r.b = ib; r.num = n; r.iv = iv; r.st = st; r.bz = bz;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = row(NC, 2'b11, mk(ALU, 3, 1, 2, 1), mk(ALU, 4, 3, 1, 1), 2, 2'b11, 0, 0);
    tbl[1]  = row(NC, 2'b11, mk(MEM, 5, 1, 0, 1), mk(ALU, 6, 5, 0, 1), 1, 2'b10, 0, 0);
    tbl[2]  = row(NC, 2'b11, mk(ALU, 6, 5, 0, 1), mk(ALU, 7, 1, 0, 1), 0, 2'b00, 0, 0);
    tbl[3]  = row(NC, 2'b11, mk(ALU, 6, 5, 0, 1), mk(ALU, 7, 1, 0, 1), 0, 2'b00, 0, 0);
    tbl[4]  = row(NC, 2'b11, mk(ALU, 6, 5, 0, 1), mk(ALU, 7, 1, 0, 1), 2, 2'b11, 0, 0);
    tbl[5]  = row(NC, 2'b11, mk(MEM, 0, 1, 2, 0), mk(MEM, 8, 1, 0, 1), 1, 2'b10, 0, 0);
    tbl[6]  = row(NC, 2'b10, mk(MEM, 8, 1, 0, 1), '0, 1, 2'b10, 0, 0);
    tbl[7]  = row(NC, 2'b11, mk(DIV, 7, 1, 2, 1), mk(ALU, 10, 7, 0, 1), 1, 2'b10, 1, 1);
    tbl[8]  = row(NC, 2'b10, mk(ALU, 10, 7, 0, 1), '0, 0, 2'b00, 0, 1);
    tbl[9]  = row(D,  2'b10, mk(ALU, 10, 7, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[10] = row(NC, 2'b10, mk(ALU, 10, 7, 0, 1), '0, 1, 2'b10, 0, 0);
    tbl[11] = row(NC, 2'b11, mk(DIV, 11, 1, 0, 1), mk(MUL, 12, 1, 0, 1), 1, 2'b10, 1, 1);
    tbl[12] = row(NC, 2'b11, mk(MUL, 12, 1, 0, 1), mk(DIV, 13, 1, 0, 1), 1, 2'b10, 0, 1);
    tbl[13] = row(D,  2'b10, mk(DIV, 13, 1, 0, 1), '0, 1, 2'b10, 1, 1);
    tbl[14] = row(S,  2'b10, mk(ALU, 15, 1, 0, 1), '0, 0, 2'b00, 0, 1);
    tbl[15] = row(NC, 2'b10, mk(ALU, 15, 12, 0, 1), '0, 0, 2'b00, 0, 1);
    tbl[16] = row(NC, 2'b10, mk(ALU, 15, 12, 0, 1), '0, 1, 2'b10, 0, 1);
    tbl[17] = row(NC, 2'b10, mk(MUL, 9, 1, 0, 1), '0, 1, 2'b10, 0, 1);
    tbl[18] = row(F,  2'b10, mk(ALU, 16, 9, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[19] = row(NC, 2'b11, mk(ALU, 16, 9, 0, 1), mk(ALU, 17, 13, 0, 1), 2, 2'b11, 0, 0);
    tbl[20] = row(NC, 2'b11, mk(MEM, 0, 1, 0, 1), mk(ALU, 18, 0, 0, 1), 2, 2'b11, 0, 0);
    tbl[21] = row(NC, 2'b11, mk(ALU, 19, 0, 0, 1), mk(ALU, 20, 0, 0, 1), 2, 2'b11, 0, 0);
    tbl[22] = row(NC, 2'b11, mk(MUL, 22, 1, 0, 1), mk(MEM, 22, 2, 0, 1), 2, 2'b11, 0, 0);
    tbl[23] = row(NC, 2'b10, mk(ALU, 23, 22, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[24] = row(NC, 2'b10, mk(ALU, 23, 22, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[25] = row(NC, 2'b10, mk(ALU, 23, 22, 0, 1), '0, 1, 2'b10, 0, 0);
    tbl[26] = row(NC, 2'b10, mk(MUL, 24, 1, 0, 1), '0, 1, 2'b10, 0, 0);
    tbl[27] = row(NC, 2'b10, mk(ALU, 24, 1, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[28] = row(NC, 2'b11, mk(ALU, 25, 1, 0, 1), mk(ALU, 26, 24, 0, 1), 1, 2'b10, 0, 0);
    tbl[29] = row(NC, 2'b10, mk(ALU, 26, 24, 0, 1), '0, 0, 2'b00, 0, 0);
    tbl[30] = row(NC, 2'b10, mk(ALU, 26, 24, 0, 1), '0, 1, 2'b10, 0, 0);
    tbl[31] = row(NC, 2'b01, '0, mk(ALU, 1, 2, 0, 1), 0, 2'b00, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_usingNUM", using_num, 0);
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_div_start", div_start, 0);
    chk("reset_div_busy", div_busy, 0);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      {flush, stall, done} = tbl[i].ctl;
      valid = tbl[i].valid;
      a = tbl[i].a;
      b = tbl[i].b;
      #1;
      chk($sformatf("row%0d_usingNUM", i), using_num, tbl[i].num);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_issue_valid", i), issue_valid, tbl[i].iv);
      chk($sformatf("row%0d_div_start", i), div_start, tbl[i].st);
      chk($sformatf("row%0d_div_busy", i), div_busy, tbl[i].bz);
    end

    @(negedge clk);
    {flush, stall, done} = NC;
    valid = 2'b10;
    a = mk(DIV, 27, 1, 0, 1);
    b = '0;
    #1;
    chk("middiv_issue", using_num, 1);
    @(posedge clk);
    #1;
    chk("middiv_busy", div_busy, 1);
    chk("middiv_start", div_start, 1);
    @(negedge clk);
    rst = 1;
    valid = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_middiv_busy", div_busy, 0);
    chk("rst_middiv_start", div_start, 0);
    chk("rst_middiv_issue_valid", issue_valid, 0);
    @(negedge clk);
    rst = 0;
    valid = 2'b10;
    a = mk(ALU, 28, 27, 0, 1);
    #1;
    chk("post_rst_reader", using_num, 1);
    @(posedge clk);
    #1;
    chk("post_rst_issue_valid", issue_valid, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
